prim_fifo_burst_reader: RTL

Single-clock consumer that drains the read port of a FIFO in bursts. It watches the FIFO's fill level, waits until a configured burst length is available, then pops exactly that many words onto a registered valid/ready output stream and marks the final word with `last`. A programmable timeout flushes a partial burst when data has waited too long. It sits in the read clock domain, directly behind `prim_fifo_async` (or any FIFO with the same read port), and is the only reader of that FIFO.

---
 rtl/prim_fifo_burst_pkg.sv | 10 +
 rtl/prim_fifo_burst_reader.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/prim_fifo_burst_pkg.sv
// Shared types for the FIFO burst reader.
package prim_fifo_burst_pkg;

    // Reader FSM: wait for enough data, then drain one burst.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_state_e;

endpackage

// File: rtl/prim_fifo_burst_reader.sv
// Drains a FIFO read port in fixed-length bursts onto a registered
// valid/ready stream, tagging the final word of each burst with last.
// A partial burst is flushed once the head word has waited timeout_i cycles.
module prim_fifo_burst_reader
    import prim_fifo_burst_pkg::*;
#(
    parameter int Width    = 16,
    parameter int Depth    = 4,
    parameter int MaxBurst = 4,
    parameter int TimeoutW = 8,
    localparam int DepthW  = $clog2(Depth + 1),
    localparam int BurstW  = $clog2(MaxBurst + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                fifo_rvalid_i,
    output logic                fifo_rready_o,
    input  logic [Width-1:0]    fifo_rdata_i,
    input  logic [DepthW-1:0]   fifo_rdepth_i,
    input  logic [BurstW-1:0]   burst_len_i,
    input  logic [TimeoutW-1:0] timeout_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [Width-1:0]    out_data_o,
    output logic                out_last_o,
    output logic                busy_o
);

    // Common width for comparing fill level against burst length.
    localparam int CntW   = (DepthW > BurstW) ? DepthW : BurstW;
    // Upper bound on a burst; never above Depth so the threshold is reachable.
    localparam int LenCap = (MaxBurst < Depth) ? MaxBurst : Depth;

    burst_state_e        state;
    burst_state_e        state_next;
    logic [TimeoutW-1:0] timer;
    logic [CntW-1:0]     beats_left;
    logic [CntW-1:0]     len_eff;
    logic [CntW-1:0]     depth_ext;
    logic                start_full;
    logic                start_flush;
    logic                pop;
    logic                out_valid;
    logic [Width-1:0]    out_data;
    logic                out_last;

    assign depth_ext = CntW'(fifo_rdepth_i);

    // Effective burst length: zero means one word, capped by MaxBurst and Depth.
    always_comb begin
        len_eff = CntW'(burst_len_i);
        if (burst_len_i == '0) begin
            len_eff = CntW'(1);
        end
        if (len_eff > CntW'(LenCap)) begin
            len_eff = CntW'(LenCap);
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, start decisions and pop request.
    always_comb begin
        state_next    = state;
        start_full    = 1'b0;
        start_flush   = 1'b0;
        fifo_rready_o = 1'b0;
        unique case (state)
            IDLE: begin
                // A full burst takes priority over a timeout flush.
                if (depth_ext >= len_eff) begin
                    start_full = 1'b1;
                    state_next = BURST;
                end else if ((timeout_i != '0) && fifo_rvalid_i && (timer >= timeout_i)) begin
                    start_flush = 1'b1;
                    state_next  = BURST;
                end
            end
            BURST: begin
                fifo_rready_o = (beats_left != '0) & (~out_valid | out_ready_i);
                // A lagging depth can start a zero-beat flush; leave at once then.
                if ((beats_left == '0) || (fifo_rvalid_i && fifo_rready_o && (beats_left == CntW'(1)))) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        pop = fifo_rvalid_i & fifo_rready_o;
    end

    // Wait timer: counts cycles the head word has been waiting while IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer <= '0;
        end else if ((state != IDLE) || start_full || start_flush || !fifo_rvalid_i) begin
            timer <= '0;
        end else if (timer != '1) begin
            timer <= timer + TimeoutW'(1);
        end
    end

    // Beat counter: loaded at burst start, decremented on each pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beats_left <= '0;
        end else if (start_full) begin
            beats_left <= len_eff;
        end else if (start_flush) begin
            beats_left <= depth_ext;
        end else if (pop) begin
            beats_left <= beats_left - CntW'(1);
        end
    end

    // One-entry output register: loads on pop, empties when accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= fifo_rdata_i;
            out_last  <= (beats_left == CntW'(1));
        end else if (out_ready_i) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    assign out_valid_o = out_valid;
    assign out_data_o  = out_data;
    assign out_last_o  = out_last;
    assign busy_o      = (state == BURST) | out_valid;

    // The FIFO cannot empty under a burst because this block is its only reader.
    rvalid_held_in_burst_a: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        ((state == BURST) && (beats_left != '0)) |-> fifo_rvalid_i
    );

endmodule
